// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  // Index of the set bit in a one-hot vector (up to 32 requesters); 0 for all-zero.
  function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = r | 5'(i);
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority search: first set req bit at or after start, wrapping N-1 -> 0.
module rr_prio_pick #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // Scan from the farthest offset back to start so the nearest hit wins.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      if (req[IDW'(c)]) begin
        found = 1'b1;
        idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// N-requester weighted round-robin arbiter with weight+1 cycle bursts.
// Define WRR_LOCK_EN to add a per-requester lock input that extends a burst.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N   = 8,
  parameter int WW  = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  arb_state_e           state;
  logic [IDW-1:0]       ptr;
  logic [WW-1:0]        credit;
  logic [N-1:0][WW-1:0] w_arr;
  logic [IDW-1:0]       owner, owner_nxt, start;
  logic                 lock_o, hold, found;
  logic [IDW-1:0]       pick_idx;

  assign w_arr     = weight;
  assign owner     = IDW'(onehot2idx(32'(grant)));
  assign owner_nxt = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;

`ifdef WRR_LOCK_EN
  assign lock_o = lock[owner];
`else
  assign lock_o = 1'b0;
`endif

  assign hold  = (state == BUSY) && req[owner] && ((credit != '0) || lock_o);
  // On release the old owner is searched last.
  assign start = (state == BUSY) ? owner_nxt : ptr;

  rr_prio_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else if (hold) begin
      if (credit != '0) credit <= credit - 1'b1;
    end else begin
      if (state == BUSY) ptr <= owner_nxt;
      if (found) begin
        state       <= BUSY;
        grant       <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        credit      <= w_arr[pick_idx];
      end else begin
        state       <= IDLE;
        grant       <= '0;
        grant_id    <= '0;
        grant_valid <= 1'b0;
        credit      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed-vector bench for wrr_arbiter (N=4 and N=5 instances).
module tb_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst4, rst5;
  logic [3:0]  req4, lock4;
  logic [4:0]  req5, lock5;
  logic [15:0] w4;
  logic [19:0] w5;
  logic [3:0]  grant4;
  logic [1:0]  gid4;
  logic        gv4;
  logic [4:0]  grant5;
  logic [2:0]  gid5;
  logic        gv5;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(4), .WW(4)) u_dut4 (
    .clk(clk), .rst(rst4), .req(req4), .weight(w4),
`ifdef WRR_LOCK_EN
    .lock(lock4),
`endif
    .grant(grant4), .grant_id(gid4), .grant_valid(gv4)
  );

  wrr_arbiter #(.N(5), .WW(4)) u_dut5 (
    .clk(clk), .rst(rst5), .req(req5), .weight(w5),
`ifdef WRR_LOCK_EN
    .lock(lock5),
`endif
    .grant(grant5), .grant_id(gid5), .grant_valid(gv5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst4 = 1'b1; req4 = '0; lock4 = '0;
    tick();
    rst4 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; rst5 = 1'b1;
    req4 = '0; req5 = '0; lock4 = '0; lock5 = '0;
    w4 = '0; w5 = '0;
    tick(); tick();
    chk("rst_grant",  32'(grant4), 32'h0);
    chk("rst_gid",    32'(gid4),   32'h0);
    chk("rst_gvalid", 32'(gv4),    32'h0);
    rst4 = 1'b0;
    tick();
    chk("idle_grant", 32'(grant4), 32'h0);

    // Plain round-robin, weights 0, all requesting.
    req4 = 4'b1111;
    begin
      logic [3:0] exp_rr [5];
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("rr_grant%0d", i), 32'(grant4), 32'(exp_rr[i]));
        chk($sformatf("rr_valid%0d", i), 32'(gv4), 32'h1);
      end
    end
    chk("rr_gid", 32'(gid4), 32'h0);

    // Weighted burst: weight[0]=2 gives 3 cycles.
    reset4();
    w4 = 16'h0002; req4 = 4'b0011;
    begin
      logic [3:0] exp_w [5];
      exp_w = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("wt_grant%0d", i), 32'(grant4), 32'(exp_w[i]));
      end
    end

    // Owner drops request mid-burst; switch directly to next requester.
    reset4();
    w4 = 16'h0700; req4 = 4'b1100;
    tick(); chk("drop_g0", 32'(grant4), 32'h4);
    tick(); chk("drop_g1", 32'(grant4), 32'h4);
    req4 = 4'b1000;
    tick(); chk("drop_g2",   32'(grant4), 32'h8);
    chk("drop_gid", 32'(gid4), 32'h3);

    // Reset mid-burst wins over the burst.
    reset4();
    w4 = 16'h0050; req4 = 4'b0010;
    tick(); chk("mid_g0", 32'(grant4), 32'h2);
    tick(); chk("mid_g1", 32'(grant4), 32'h2);
    rst4 = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(grant4), 32'h0);
    chk("mid_rst_gid",   32'(gid4),   32'h0);
    chk("mid_rst_valid", 32'(gv4),    32'h0);
    rst4 = 1'b0; req4 = 4'b1010;
    tick();
    chk("post_rst_grant", 32'(grant4), 32'h2);
    chk("post_rst_gid",   32'(gid4),   32'h1);

`ifdef WRR_LOCK_EN
    // Lock holds a weight-0 owner beyond its credit.
    reset4();
    w4 = '0; lock4 = 4'b0010; req4 = 4'b0010;
    tick(); chk("lock_g0", 32'(grant4), 32'h2);
    req4 = 4'b0011;
    for (int i = 1; i < 6; i++) begin
      tick(); chk($sformatf("lock_g%0d", i), 32'(grant4), 32'h2);
    end
    lock4 = '0;
    tick(); chk("lock_rel", 32'(grant4), 32'h1);
`endif

    // Non-power-of-two wrap: N=5, req[4] and req[0].
    rst5 = 1'b0; req5 = 5'b10001;
    begin
      logic [2:0] exp_id [4];
      exp_id = '{3'd0, 3'd4, 3'd0, 3'd4};
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("wrap5_gid%0d", i), 32'(gid5), 32'(exp_id[i]));
      end
    end
    chk("wrap5_grant", 32'(grant5), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
